// File: rtl/pkt_reader.sv
// ---------------------------------------------------------------------------
// pkt_reader
// Egress-side packet reader for the shared SRAM packet buffer. Descriptors
// from the write-side allocator are queued in eight per-priority FIFOs. The
// reader picks the next packet, streams its words out of the SRAM one word
// at a time over a valid/ready interface, then pulses rea/chain_id so the
// chain manager can release the packet's block.
//
// Build option:
//   PKT_READER_RR_EN  defined   -> round-robin selection across non-empty
//                                  priorities, pointer resets to 7 so that
//                                  priority 0 is looked at first.
//                     undefined -> strict priority, lowest number wins.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   enq_valid/enq_ready              descriptor enqueue handshake
//   enq_prio/enq_chain_id/enq_addr/enq_size   descriptor fields
//   sram_re/sram_addr/sram_rdata     SRAM read port (1-cycle read latency)
//   out_valid/out_ready/out_data/out_sop/out_eop   word stream
//   rea/chain_id                     one-cycle release pulse + node id
//   busy                             reader is working on a packet
// ---------------------------------------------------------------------------
module pkt_reader #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [2:0]        enq_prio,
    input  logic [8:0]        enq_chain_id,
    input  logic [ADDR_W-1:0] enq_addr,
    input  logic [7:0]        enq_size,
    output logic              sram_re,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sop,
    output logic              out_eop,
    output logic              rea,
    output logic [8:0]        chain_id,
    output logic              busy
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 9 + ADDR_W + 8;   // {chain_id, addr, size}

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_WAIT = 3'd2,
        ST_OUT  = 3'd3,
        ST_FREE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [8:0]        id_q, id_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        size_q, size_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              sop_q, sop_d;
    logic              eop_q, eop_d;

    logic [7:0]          not_empty;
    logic [7:0]          full;
    logic [7:0][EW-1:0]  head;
    logic [EW-1:0]       enq_data;
    logic                push_fire;
    logic                pop_fire;
    logic [2:0]          sel;

    // enq_ready looks only at the current count, so a full FIFO stays closed
    // even in a cycle where it is being popped.
    assign enq_ready = ~full[enq_prio];
    // Zero-length descriptors are consumed but never stored.
    assign push_fire = enq_valid & enq_ready & (enq_size != 8'd0);
    assign enq_data  = {enq_chain_id, enq_addr, enq_size};

    // ------------------------------------------------------------------
    // Per-priority descriptor FIFOs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < 8; gi++) begin : g_fifo
        logic [EW-1:0] mem [DEPTH];
        logic [PW-1:0] wr_ptr_q, wr_ptr_d;
        logic [PW-1:0] rd_ptr_q, rd_ptr_d;
        logic [CW-1:0] count_q, count_d;
        logic          push_g;
        logic          pop_g;

        assign push_g = push_fire & (enq_prio == 3'(gi));
        assign pop_g  = pop_fire & (sel == 3'(gi));

        always_comb begin
            wr_ptr_d = wr_ptr_q;
            rd_ptr_d = rd_ptr_q;
            count_d  = count_q;
            if (push_g) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_g) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            // Simultaneous push and pop leave the count unchanged.
            if (push_g && !pop_g) begin
                count_d = count_q + CW'(1);
            end else if (pop_g && !push_g) begin
                count_d = count_q - CW'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_d;
                rd_ptr_q <= rd_ptr_d;
                count_q  <= count_d;
            end
        end

        // Storage is not reset; the counters alone define validity.
        always_ff @(posedge clk) begin
            if (push_g) begin
                mem[wr_ptr_q] <= enq_data;
            end
        end

        assign head[gi]      = mem[rd_ptr_q];
        assign not_empty[gi] = (count_q != '0);
        assign full[gi]      = (count_q == CW'(DEPTH));
    end

    // ------------------------------------------------------------------
    // Selector
    // ------------------------------------------------------------------
`ifdef PKT_READER_RR_EN
    logic [2:0] rr_ptr_q, rr_ptr_d;
    logic [2:0] rr_idx;
    logic       rr_found;

    // Scan starts one past the last served priority and wraps around.
    always_comb begin
        sel      = 3'd0;
        rr_idx   = 3'd0;
        rr_found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            rr_idx = rr_ptr_q + 3'(i);
            if (!rr_found && not_empty[rr_idx]) begin
                sel      = rr_idx;
                rr_found = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (pop_fire) begin
            rr_ptr_d = sel;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q <= 3'd7;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (not_empty[i]) begin
                sel = 3'(i);
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Read FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            id_q    <= '0;
            base_q  <= '0;
            size_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            base_q  <= base_d;
            size_q  <= size_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        id_d      = id_q;
        base_d    = base_q;
        size_d    = size_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        sop_d     = sop_q;
        eop_d     = eop_q;
        pop_fire  = 1'b0;
        sram_re   = 1'b0;
        sram_addr = '0;
        rea       = 1'b0;
        chain_id  = '0;

        case (state_q)
            ST_IDLE: begin
                if (|not_empty) begin
                    pop_fire = 1'b1;
                    {id_d, base_d, size_d} = head[sel];
                    cnt_d   = 8'd0;
                    state_d = ST_RD;
                end
            end
            ST_RD: begin
                sram_re   = 1'b1;
                // Natural ADDR_W-bit overflow gives the wrap past the top.
                sram_addr = base_q + ADDR_W'(cnt_q);
                state_d   = ST_WAIT;
            end
            ST_WAIT: begin
                data_d  = sram_rdata;
                sop_d   = (cnt_q == 8'd0);
                eop_d   = (cnt_q == size_q - 8'd1);
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + 8'd1;
                    state_d = eop_q ? ST_FREE : ST_RD;
                end
            end
            ST_FREE: begin
                rea      = 1'b1;
                chain_id = id_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign out_valid = (state_q == ST_OUT);
    assign out_data  = data_q;
    assign out_sop   = sop_q;
    assign out_eop   = eop_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pkt_reader.sv
// ---------------------------------------------------------------------------
// tb_pkt_reader
// Self-checking bench for pkt_reader. A behavioural reference keeps the
// descriptor FIFOs as queues, picks packets by the priority rule, and
// tracks the word slot each packet is in to predict every output on every
// cycle. A simple SRAM model returns an address-derived word one cycle
// after each read strobe. Directed scenarios are followed by random traffic.
// ---------------------------------------------------------------------------
module tb_pkt_reader;

    localparam int DEPTH = 16;

    typedef struct packed {
        logic [8:0]  id;
        logic [11:0] addr;
        logic [7:0]  size;
    } desc_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enq_valid = 1'b0;
    logic        enq_ready;
    logic [2:0]  enq_prio = '0;
    logic [8:0]  enq_chain_id = '0;
    logic [11:0] enq_addr = '0;
    logic [7:0]  enq_size = '0;
    logic        sram_re;
    logic [11:0] sram_addr;
    logic [63:0] sram_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_sop;
    logic        out_eop;
    logic        rea;
    logic [8:0]  chain_id;
    logic        busy;

    pkt_reader #(.DEPTH(DEPTH), .DATA_W(64), .ADDR_W(12)) dut (
        .clk          (clk),
        .rst          (rst),
        .enq_valid    (enq_valid),
        .enq_ready    (enq_ready),
        .enq_prio     (enq_prio),
        .enq_chain_id (enq_chain_id),
        .enq_addr     (enq_addr),
        .enq_size     (enq_size),
        .sram_re      (sram_re),
        .sram_addr    (sram_addr),
        .sram_rdata   (sram_rdata),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .rea          (rea),
        .chain_id     (chain_id),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] sdata(input logic [11:0] a);
        return {16'hC0DE, 4'h0, a, 20'hF0F0F, ~a};
    endfunction

    // SRAM: data for the strobed address appears the following cycle;
    // otherwise the bus carries junk.
    always @(posedge clk) begin
        if (sram_re) sram_rdata <= sdata(sram_addr);
        else         sram_rdata <= {$urandom, $urandom};
    end

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s cycle=%0d got=%h exp=%h", tag, cyc, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    // ---------------- reference model ----------------
    desc_t       mq [8][$];
    // 0 idle, 1 read slot, 2 capture slot, 3 presenting word, 4 release
    int          m_phase = 0;
    desc_t       m_cur;
    int          m_k = 0;
    logic [63:0] m_data = '0;
    logic        m_sop = 1'b0;
    logic        m_eop = 1'b0;
    int          m_last = 7;

    function automatic int pick();
`ifdef PKT_READER_RR_EN
        for (int i = 1; i <= 8; i++) begin
            int p;
            p = (m_last + i) % 8;
            if (mq[p].size() != 0) return p;
        end
`else
        for (int i = 0; i < 8; i++) begin
            if (mq[i].size() != 0) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [11:0] word_addr(input int k);
        return 12'((int'(m_cur.addr) + k) % 4096);
    endfunction

    function automatic bit model_empty();
        for (int i = 0; i < 8; i++) if (mq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // Staged inputs, applied just after the next rising edge.
    logic        s_rst = 1'b1;
    logic        s_valid = 1'b0;
    logic [2:0]  s_prio = '0;
    logic [8:0]  s_id = '0;
    logic [11:0] s_addr = '0;
    logic [7:0]  s_size = '0;
    logic        s_ready = 1'b0;

    task automatic step();
        bit fire;
        int p;
        @(posedge clk);
        #1;
        rst          = s_rst;
        enq_valid    = s_valid;
        enq_prio     = s_prio;
        enq_chain_id = s_id;
        enq_addr     = s_addr;
        enq_size     = s_size;
        out_ready    = s_ready;
        #1;
        cyc++;
        chk("busy",      64'(busy),      64'(m_phase != 0));
        chk("sram_re",   64'(sram_re),   64'(m_phase == 1));
        chk("sram_addr", 64'(sram_addr), 64'((m_phase == 1) ? word_addr(m_k) : 12'd0));
        chk("out_valid", 64'(out_valid), 64'(m_phase == 3));
        chk("out_data",  out_data,       m_data);
        chk("out_sop",   64'(out_sop),   64'(m_sop));
        chk("out_eop",   64'(out_eop),   64'(m_eop));
        chk("rea",       64'(rea),       64'(m_phase == 4));
        chk("chain_id",  64'(chain_id),  64'((m_phase == 4) ? m_cur.id : 9'd0));
        chk("enq_ready", 64'(enq_ready), 64'(mq[enq_prio].size() < DEPTH));

        if (rst) begin
            for (int i = 0; i < 8; i++) mq[i].delete();
            m_phase = 0; m_k = 0; m_data = '0; m_sop = 1'b0; m_eop = 1'b0;
            m_last = 7; m_cur = '0;
        end else begin
            fire = enq_valid && (mq[enq_prio].size() < DEPTH);
            case (m_phase)
                0: begin
                    p = pick();
                    if (p >= 0) begin
                        m_cur = mq[p].pop_front();
                        m_last = p; m_k = 0; m_phase = 1;
                    end
                end
                1: m_phase = 2;
                2: begin
                    m_data = sdata(word_addr(m_k));
                    m_sop  = (m_k == 0);
                    m_eop  = (m_k == int'(m_cur.size) - 1);
                    m_phase = 3;
                end
                3: if (out_ready) begin
                    m_k++;
                    m_phase = m_eop ? 4 : 1;
                end
                default: begin
                    $display("pkt release id=%0d size=%0d addr=%h cycle=%0d",
                             m_cur.id, m_cur.size, m_cur.addr, cyc);
                    m_phase = 0;
                end
            endcase
            if (fire && enq_size != 8'd0)
                mq[enq_prio].push_back('{id: enq_chain_id, addr: enq_addr, size: enq_size});
        end
    endtask

    task automatic enq(input int prio, input int id, input int addr, input int size);
        s_valid = 1'b1; s_prio = 3'(prio); s_id = 9'(id);
        s_addr = 12'(addr); s_size = 8'(size);
        step();
        s_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic drain();
        int t;
        s_ready = 1'b1;
        t = 0;
        while (!(m_phase == 0 && model_empty()) && t < 3000) begin
            step(); t++;
        end
        chk("drain_timeout", 64'(t >= 3000), 64'(0));
        run(2);
    endtask

    task automatic wait_word(input int k);
        int t;
        t = 0;
        while (!(m_phase == 3 && m_k == k) && t < 500) begin
            step(); t++;
        end
        chk("wait_word_timeout", 64'(t >= 500), 64'(0));
    endtask

    initial begin
        // reset
        s_rst = 1'b1;
        run(3);
        s_rst = 1'b0;
        run(2);

        // single-word packet
        s_ready = 1'b1;
        enq(3, 5, 12'h010, 1);
        run(8);

        // ordering: stall a packet, then queue prio 4 and prio 1 behind it
        s_ready = 1'b0;
        enq(0, 9, 12'h100, 3);
        wait_word(0);
        enq(4, 1, 12'h200, 2);
        enq(1, 2, 12'h300, 1);
        run(3);
        drain();

        // address wrap
        enq(5, 7, 12'hFFE, 4);
        drain();

        // long stall mid-packet
        enq(6, 3, 12'h040, 3);
        wait_word(1);
        s_ready = 1'b0;
        run(10);
        drain();

        // fill prio 2 while the reader is stalled on a prio 0 packet
        s_ready = 1'b0;
        enq(0, 10, 12'h500, 2);
        wait_word(0);
        for (int i = 0; i < DEPTH; i++) enq(2, 100 + i, i * 8, 1);
        enq(2, 199, 12'h7F0, 1);           // rejected: full
        enq(0, 11, 12'h510, 1);            // accepted: prio 0 has room
        // keep offering to prio 2 through the moment it is first popped
        s_ready = 1'b1;
        s_valid = 1'b1; s_prio = 3'd2; s_id = 9'd200; s_addr = 12'h800; s_size = 8'd2;
        run(14);
        s_valid = 1'b0;
        drain();

        // reset during the second word of a 3-word packet
        s_ready = 1'b1;
        enq(1, 50, 12'h600, 3);
        enq(7, 51, 12'h610, 2);
        enq(4, 52, 12'h620, 1);
        wait_word(1);
        s_rst = 1'b1;
        step();
        s_rst = 1'b0;
        run(6);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom_range(0, 9) < 3);
            s_prio  = 3'($urandom_range(0, 7));
            s_id    = 9'($urandom);
            s_addr  = 12'($urandom);
            s_size  = 8'($urandom_range(0, 6));
            s_ready = ($urandom_range(0, 9) < 7);
            s_rst   = ($urandom_range(0, 999) == 0);
            step();
        end
        s_valid = 1'b0;
        s_rst   = 1'b0;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pkt_reader.md
# pkt_reader

Output-side packet reader for one egress port of the shared SRAM packet buffer. It holds descriptors (chain_id, start address, size, priority) produced by the write-side allocator in eight priority FIFOs. It selects the next packet, streams its words out of the SRAM with a valid/ready handshake, and then pulses `rea`/`chain_id` so the chain manager releases the packet's block. It is the reader counterpart to the allocator's write path; one instance sits per egress port.

## Interface
Parameters:
- `DEPTH`, 16: descriptor FIFO entries per priority (power of two).
- `DATA_W`, 64: SRAM word width, 8 bytes.
- `ADDR_W`, 12: SRAM word address width.

Ports (clock and reset first):
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  reset, synchronous, active-high.
- `enq_valid`  in  1  descriptor offered.
- `enq_ready`  out  1  FIFO[`enq_prio`] not full (combinational from `enq_prio`).
- `enq_prio`  in  3  priority 0..7; 0 is highest.
- `enq_chain_id`  in  9  chain node id of the packet.
- `enq_addr`  in  ADDR_W  start word address.
- `enq_size`  in  8  packet length in words.
- `sram_re`  out  1  SRAM read strobe.
- `sram_addr`  out  ADDR_W  SRAM read address.
- `sram_rdata`  in  DATA_W  read data, valid exactly 1 cycle after `sram_re`.
- `out_valid`  out  1  output word valid.
- `out_ready`  in  1  downstream accepts.
- `out_data`  out  DATA_W  output word.
- `out_sop`  out  1  first word of packet.
- `out_eop`  out  1  last word of packet.
- `rea`  out  1  one-cycle release pulse to the chain manager.
- `chain_id`  out  9  node id accompanying `rea`.
- `busy`  out  1  FSM not in IDLE.

## Operation
- Enqueue fires when `enq_valid && enq_ready`. A descriptor with `enq_size==0` is accepted and discarded: nothing is stored and no `rea` is issued.
- `enq_ready` reflects the current count only. When a FIFO is full, a pop in the same cycle does not make room for a simultaneous push.
- Enqueue and dequeue may hit the same FIFO in the same cycle; both take effect.
- FSM states:
  - IDLE: if any FIFO is non-empty, pop the selected FIFO's head into the packet registers (id, base, size), clear the word counter, and go to RD. Otherwise stay in IDLE.
  - RD: `sram_re=1`, `sram_addr=(base+cnt) mod 2^ADDR_W`, then go to WAIT.
  - WAIT: capture `sram_rdata` into `out_data`, set `out_sop=(cnt==0)` and `out_eop=(cnt==size-1)`, then go to OUT.
  - OUT: `out_valid=1`, with data, sop and eop held stable. On `out_ready`: `cnt++`; go to FREE if eop, else RD.
  - FREE: `rea=1`, `chain_id`=packet id, then go to IDLE.
- Address arithmetic wraps modulo 2^ADDR_W. A packet that crosses address 4095 continues at 0.
- Size arithmetic is 8-bit unsigned, and `size-1` is evaluated only for size ≥ 1.
- Reset at any point, including mid-packet, behaves as follows:
  - all FIFOs are emptied;
  - the FSM goes to IDLE;
  - the in-flight packet is dropped with no `rea`;
  - all outputs return to their reset values.

## Timing
- Reset values: `enq_ready`=1, `sram_re`=0, `sram_addr`=0, `out_valid`=0, `out_data`=0, `out_sop`=0, `out_eop`=0, `rea`=0, `chain_id`=0, `busy`=0.
- A descriptor enqueued at cycle T is eligible for selection at T+1.
- Pop at cycle P (IDLE) leads to `sram_re` at P+1 and `out_valid` at P+3.
- The minimum word period is 3 cycles (RD, WAIT, OUT with `out_ready` high). A packet of N words with constant `out_ready` takes 3N+2 cycles from pop to the end of FREE.
- `out_valid` is never deasserted before the handshake; `out_data`, `out_sop` and `out_eop` are stable while `out_valid` is high.
- `rea` is high for exactly one cycle, one cycle after the eop handshake.
- `sram_re` is high for exactly one cycle per word.

## Configuration
- `PKT_READER_RR_EN`:
  - Defined: the selector is round-robin across non-empty priorities, starting after the last served priority. The pointer resets to 7, so priority 0 is served first.
  - Undefined: strict priority; the lowest-numbered non-empty FIFO always wins.
  - FIFO, FSM and timing behaviour is identical in both builds.

## Test plan
- Enqueue {prio 3, id 5, addr 0x010, size 1} with `out_ready` held 1: one word from 0x010 with sop=eop=1; `out_valid` 3 cycles after pop; then `rea`=1 with `chain_id`=5.
- Enqueue prio 4 {id 1, size 2}, then prio 1 {id 2, size 1}, both before the FSM leaves IDLE. Strict build: id 2 first, then id 1. With `PKT_READER_RR_EN` the order follows the pointer: 0, then 1 (id 2), then … 4 (id 1).
- Packet at addr 0xFFE, size 4: `sram_addr` sequence 0xFFE, 0xFFF, 0x000, 0x001.
- Hold `out_ready`=0 for 10 cycles mid-packet: `out_valid` stays 1, `out_data` is unchanged, and no `sram_re` is issued until the handshake completes.
- Fill prio 2 with 16 entries: `enq_ready`=0 for prio 2 while prio 0 still accepts. Offering a push in the same cycle as a pop of the full prio 2 FIFO is rejected.
- Assert `rst` during the second word of a 3-word packet: no `rea` is issued, outputs read their reset values the next cycle, and all FIFOs are empty.
